// File: rtl/choose_cursor_ctrl.sv
// Cursor and two-player pick controller for the choose scene's 2x4 Pokemon grid.
// Optional edge wrap-around is enabled by defining CHOOSE_CURSOR_WRAP_EN.
module choose_cursor_ctrl #(
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scene_active,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_enter,
    input  logic       key_back,
    output logic [7:0] pokemon_id,
    output logic       cursor_show,
    output logic [7:0] p1_id,
    output logic [7:0] p2_id,
    output logic       pick_turn,
    output logic       done,
    output logic       reject
);

`ifdef CHOOSE_CURSOR_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam int CNT_W = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PICK1 = 2'd1,
        ST_PICK2 = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        K_NONE  = 3'd0,
        K_ENTER = 3'd1,
        K_BACK  = 3'd2,
        K_UP    = 3'd3,
        K_DOWN  = 3'd4,
        K_LEFT  = 3'd5,
        K_RIGHT = 3'd6
    } key_t;

    state_t           state_r;
    logic [CNT_W-1:0] blink_cnt_r;
    key_t             key_s;
    logic [1:0]       col_s;
    logic             top_s;
    logic             in_pick_s;
    logic             move_ok_s;
    logic [7:0]       move_dst_s;
    logic             enter_ok_s;
    logic             enter_rej_s;
    logic             back_ok_s;
    logic             restart_s;
    logic             blink_tc_s;

    // Cursor 1..8 maps to column (id-1) mod 4, which only needs the low two bits.
    assign col_s      = pokemon_id[1:0] - 2'd1;
    assign top_s      = (pokemon_id < 8'd5);
    assign in_pick_s  = (state_r == ST_PICK1) || (state_r == ST_PICK2);
    assign blink_tc_s = (blink_cnt_r == CNT_LAST);

    // Pick the single highest-priority key pulse of this cycle.
    always_comb begin
        key_s = K_NONE;
        if (key_enter) begin
            key_s = K_ENTER;
        end else if (key_back) begin
            key_s = K_BACK;
        end else if (key_up) begin
            key_s = K_UP;
        end else if (key_down) begin
            key_s = K_DOWN;
        end else if (key_left) begin
            key_s = K_LEFT;
        end else if (key_right) begin
            key_s = K_RIGHT;
        end else begin
            key_s = K_NONE;
        end
    end

    // Destination of the selected move and whether it stays on the grid.
    always_comb begin
        move_ok_s  = 1'b0;
        move_dst_s = pokemon_id;
        case (key_s)
            K_UP: begin
                if (!top_s) begin
                    move_ok_s  = in_pick_s;
                    move_dst_s = pokemon_id - 8'd4;
                end else if (WRAP_EN) begin
                    move_ok_s  = in_pick_s;
                    move_dst_s = pokemon_id + 8'd4;
                end else begin
                    move_ok_s  = 1'b0;
                end
            end
            K_DOWN: begin
                if (top_s) begin
                    move_ok_s  = in_pick_s;
                    move_dst_s = pokemon_id + 8'd4;
                end else if (WRAP_EN) begin
                    move_ok_s  = in_pick_s;
                    move_dst_s = pokemon_id - 8'd4;
                end else begin
                    move_ok_s  = 1'b0;
                end
            end
            K_LEFT: begin
                if (col_s != 2'd0) begin
                    move_ok_s  = in_pick_s;
                    move_dst_s = pokemon_id - 8'd1;
                end else if (WRAP_EN) begin
                    move_ok_s  = in_pick_s;
                    move_dst_s = pokemon_id + 8'd3;
                end else begin
                    move_ok_s  = 1'b0;
                end
            end
            K_RIGHT: begin
                if (col_s != 2'd3) begin
                    move_ok_s  = in_pick_s;
                    move_dst_s = pokemon_id + 8'd1;
                end else if (WRAP_EN) begin
                    move_ok_s  = in_pick_s;
                    move_dst_s = pokemon_id - 8'd3;
                end else begin
                    move_ok_s  = 1'b0;
                end
            end
            default: begin
                move_ok_s  = 1'b0;
                move_dst_s = pokemon_id;
            end
        endcase
    end

    // Classify enter/back; any accepted action restarts the blink period.
    always_comb begin
        enter_ok_s  = (key_s == K_ENTER) &&
                      ((state_r == ST_PICK1) || ((state_r == ST_PICK2) && (pokemon_id != p1_id)));
        enter_rej_s = (key_s == K_ENTER) && (state_r == ST_PICK2) && (pokemon_id == p1_id);
        back_ok_s   = (key_s == K_BACK) && ((state_r == ST_PICK2) || (state_r == ST_DONE));
        restart_s   = enter_ok_s || back_ok_s || move_ok_s;
    end

    // Pick sequencer with registered outputs and blink timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            blink_cnt_r <= '0;
            pokemon_id  <= 8'd0;
            cursor_show <= 1'b0;
            p1_id       <= 8'd0;
            p2_id       <= 8'd0;
            pick_turn   <= 1'b0;
            done        <= 1'b0;
            reject      <= 1'b0;
        end else if (!scene_active) begin
            state_r     <= ST_IDLE;
            blink_cnt_r <= '0;
            pokemon_id  <= 8'd0;
            cursor_show <= 1'b0;
            p1_id       <= 8'd0;
            p2_id       <= 8'd0;
            pick_turn   <= 1'b0;
            done        <= 1'b0;
            reject      <= 1'b0;
        end else begin
            reject <= enter_rej_s;
            case (state_r)
                ST_IDLE: begin
                    state_r     <= ST_PICK1;
                    pokemon_id  <= 8'd1;
                    cursor_show <= 1'b1;
                    blink_cnt_r <= '0;
                end
                ST_PICK1, ST_PICK2: begin
                    if (enter_ok_s && (state_r == ST_PICK1)) begin
                        p1_id     <= pokemon_id;
                        state_r   <= ST_PICK2;
                        pick_turn <= 1'b1;
                    end else if (enter_ok_s) begin
                        p2_id   <= pokemon_id;
                        state_r <= ST_DONE;
                        done    <= 1'b1;
                    end else if (back_ok_s) begin
                        p1_id     <= 8'd0;
                        state_r   <= ST_PICK1;
                        pick_turn <= 1'b0;
                    end else if (move_ok_s) begin
                        pokemon_id <= move_dst_s;
                    end else begin
                        state_r <= state_r;
                    end
                    if (restart_s) begin
                        cursor_show <= 1'b1;
                        blink_cnt_r <= '0;
                    end else if (blink_tc_s) begin
                        cursor_show <= ~cursor_show;
                        blink_cnt_r <= '0;
                    end else begin
                        blink_cnt_r <= blink_cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    if (back_ok_s) begin
                        p2_id   <= 8'd0;
                        state_r <= ST_PICK2;
                        done    <= 1'b0;
                    end else begin
                        state_r <= ST_DONE;
                    end
                    cursor_show <= 1'b1;
                    blink_cnt_r <= '0;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_choose_cursor_ctrl.sv
// Randomized bench for choose_cursor_ctrl against a grid-level reference model.
module tb_choose_cursor_ctrl;

    localparam int BLINK = 4;

`ifdef CHOOSE_CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scene_active = 1'b0;
    logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
    logic       key_enter = 1'b0, key_back = 1'b0;
    logic [7:0] pokemon_id, p1_id, p2_id;
    logic       cursor_show, pick_turn, done, reject;

    choose_cursor_ctrl #(.BLINK_CYCLES(BLINK)) dut (
        .clk(clk), .rst(rst), .scene_active(scene_active),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .key_enter(key_enter), .key_back(key_back),
        .pokemon_id(pokemon_id), .cursor_show(cursor_show), .p1_id(p1_id), .p2_id(p2_id),
        .pick_turn(pick_turn), .done(done), .reject(reject)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: phase 0 idle, 1 player-1 choosing, 2 player-2 choosing, 3 both picked.
    int m_phase, m_cur, m_p1, m_p2, m_show, m_age, m_rej;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic compare_all();
        check_eq("pokemon_id",  32'(pokemon_id),  32'((m_phase == 0) ? 0 : m_cur));
        check_eq("cursor_show", 32'(cursor_show), 32'(m_show));
        check_eq("p1_id",       32'(p1_id),       32'(m_p1));
        check_eq("p2_id",       32'(p2_id),       32'(m_p2));
        check_eq("pick_turn",   32'(pick_turn),   32'((m_phase >= 2) ? 1 : 0));
        check_eq("done",        32'(done),        32'((m_phase == 3) ? 1 : 0));
        check_eq("reject",      32'(reject),      32'(m_rej));
    endtask

    // Grid move using row/column arithmetic; returns 0 when the move leaves the grid.
    function automatic int grid_move(input int c, input int dir);
        int row, col;
        row = (c - 1) / 4;
        col = (c - 1) % 4;
        case (dir)
            0: begin if (row == 0) begin if (!WRAP) return 0; row = 1; end else row = 0; end
            1: begin if (row == 1) begin if (!WRAP) return 0; row = 0; end else row = 1; end
            2: begin if (col == 0) begin if (!WRAP) return 0; col = 3; end else col = col - 1; end
            default: begin if (col == 3) begin if (!WRAP) return 0; col = 0; end else col = col + 1; end
        endcase
        return row * 4 + col + 1;
    endfunction

    // k = {enter, back, up, down, left, right}
    task automatic model_step(input logic r, input logic sa, input logic [5:0] k);
        bit acted;
        int nxt;
        if (r || !sa) begin
            m_phase = 0; m_cur = 0; m_p1 = 0; m_p2 = 0; m_show = 0; m_age = 0; m_rej = 0;
        end else if (m_phase == 0) begin
            m_phase = 1; m_cur = 1; m_show = 1; m_age = 0; m_rej = 0;
        end else if (m_phase == 3) begin
            m_rej = 0;
            if (!k[5] && k[4]) begin
                m_p2 = 0; m_phase = 2;
            end
            m_show = 1; m_age = 0;
        end else begin
            m_rej = 0;
            acted = 1'b0;
            if (k[5]) begin
                if (m_phase == 1) begin m_p1 = m_cur; m_phase = 2; acted = 1'b1; end
                else if (m_cur != m_p1) begin m_p2 = m_cur; m_phase = 3; acted = 1'b1; end
                else m_rej = 1;
            end else if (k[4]) begin
                if (m_phase == 2) begin m_p1 = 0; m_phase = 1; acted = 1'b1; end
            end else if (k[3:0] != 4'd0) begin
                nxt = k[3] ? grid_move(m_cur, 0) : k[2] ? grid_move(m_cur, 1) :
                      k[1] ? grid_move(m_cur, 2) : grid_move(m_cur, 3);
                if (nxt != 0) begin m_cur = nxt; acted = 1'b1; end
            end
            if (acted) begin
                m_show = 1; m_age = 0;
            end else if (m_age == BLINK - 1) begin
                m_show = 1 - m_show; m_age = 0;
            end else begin
                m_age = m_age + 1;
            end
        end
    endtask

    task automatic do_cycle(input logic r, input logic sa, input logic [5:0] k);
        @(negedge clk);
        compare_all();
        rst = r;
        scene_active = sa;
        {key_enter, key_back, key_up, key_down, key_left, key_right} = k;
        model_step(r, sa, k);
        cyc++;
    endtask

    initial begin
        logic [5:0] k;
        logic       sa, r;
        int         p;
        m_phase = 0; m_cur = 0; m_p1 = 0; m_p2 = 0; m_show = 0; m_age = 0; m_rej = 0;
        repeat (2) @(negedge clk);

        // Directed walk through the documented scenario.
        do_cycle(1'b1, 1'b0, 6'b000000);
        do_cycle(1'b0, 1'b1, 6'b000000);
        do_cycle(1'b0, 1'b1, 6'b000001);
        do_cycle(1'b0, 1'b1, 6'b000001);
        do_cycle(1'b0, 1'b1, 6'b000100);
        do_cycle(1'b0, 1'b1, 6'b000011);
        do_cycle(1'b0, 1'b1, 6'b001000);
        do_cycle(1'b0, 1'b1, 6'b000001);
        do_cycle(1'b0, 1'b1, 6'b000001);
        do_cycle(1'b0, 1'b1, 6'b000001);
        do_cycle(1'b0, 1'b1, 6'b001000);
        do_cycle(1'b0, 1'b1, 6'b100000);
        do_cycle(1'b0, 1'b1, 6'b100000);
        do_cycle(1'b0, 1'b1, 6'b000100);
        do_cycle(1'b0, 1'b1, 6'b000001);
        do_cycle(1'b0, 1'b1, 6'b100000);
        do_cycle(1'b0, 1'b1, 6'b100100);
        do_cycle(1'b0, 1'b1, 6'b010000);
        do_cycle(1'b0, 1'b1, 6'b010000);
        repeat (10) do_cycle(1'b0, 1'b1, 6'b000000);
        do_cycle(1'b0, 1'b1, 6'b000010);
        repeat (9) do_cycle(1'b0, 1'b1, 6'b000000);
        do_cycle(1'b0, 1'b0, 6'b100000);
        do_cycle(1'b0, 1'b1, 6'b000000);
        do_cycle(1'b1, 1'b1, 6'b000000);
        do_cycle(1'b0, 1'b1, 6'b000000);

        // Randomized traffic with occasional scene drops and mid-sequence resets.
        for (int i = 0; i < 4000; i++) begin
            p = $urandom_range(0, 99);
            if (p < 40)      k = 6'b000000;
            else if (p < 80) k = 6'(1 << $urandom_range(0, 5));
            else             k = 6'($urandom);
            sa = ($urandom_range(0, 149) != 0);
            r  = ($urandom_range(0, 399) == 0);
            do_cycle(r, sa, k);
        end

        @(negedge clk);
        compare_all();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
